// File: rtl/multi_channel_delay_timer.sv
// NUM_CH independent one-shot delay timers with cancel, retrigger, done pulse and sticky done flag.
// Define DELAY_REMAIN_EN to expose each channel's live counter on the remain port.
module multi_channel_delay_timer #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       cancel,
   input  logic [NUM_CH-1:0]       retrig,
   input  logic [NUM_CH*CNT_W-1:0] delay_val,
   input  logic [NUM_CH-1:0]       clr_done,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       done_pulse,
   output logic [NUM_CH-1:0]       done_level,
   output logic                    any_done
`ifdef DELAY_REMAIN_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] remain
`endif
);

   typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_e           state_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] load_val;
      logic             busy_q;
      logic             pulse_q;
      logic             level_q;

      // A zero delay is treated as one cycle so the counter always terminates at 1.
      assign load_val = (delay_val[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                            : delay_val[i*CNT_W +: CNT_W];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
         end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
               StIdle: begin
                  if (start[i] && !cancel[i]) begin
                     state_q <= StCount;
                     cnt_q   <= load_val;
                     busy_q  <= 1'b1;
                     level_q <= 1'b0;
                  end
               end
               StCount: begin
                  if (cancel[i]) begin
                     state_q <= StIdle;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                  end else if (start[i] && retrig[i]) begin
                     // Reload beats expiry on the same edge.
                     cnt_q <= load_val;
                  end else if (cnt_q == CNT_W'(1)) begin
                     state_q <= StDone;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                     pulse_q <= 1'b1;
                     level_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               StDone: begin
                  if (cancel[i]) begin
                     state_q <= StIdle;
                     level_q <= 1'b0;
                  end else if (start[i]) begin
                     state_q <= StCount;
                     cnt_q   <= load_val;
                     busy_q  <= 1'b1;
                     level_q <= 1'b0;
                  end else if (clr_done[i]) begin
                     state_q <= StIdle;
                     level_q <= 1'b0;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  level_q <= 1'b0;
               end
            endcase
         end
      end

      assign busy[i]       = busy_q;
      assign done_pulse[i] = pulse_q;
      assign done_level[i] = level_q;
`ifdef DELAY_REMAIN_EN
      // Counter is held at zero outside COUNT, so it can be exported directly.
      assign remain[i*CNT_W +: CNT_W] = cnt_q;
`endif
   end

   assign any_done = |done_level;

endmodule

// File: tb/tb_multi_channel_delay_timer.sv
// Scoreboard bench: stimulus pushes the expected done_pulse cycle per channel, a monitor
// pops and compares on every observed pulse.
module tb_multi_channel_delay_timer;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 4;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b1;
   logic [NUM_CH-1:0]       start = '0;
   logic [NUM_CH-1:0]       cancel = '0;
   logic [NUM_CH-1:0]       retrig = '0;
   logic [NUM_CH*CNT_W-1:0] delay_val = '0;
   logic [NUM_CH-1:0]       clr_done = '0;
   logic [NUM_CH-1:0]       busy;
   logic [NUM_CH-1:0]       done_pulse;
   logic [NUM_CH-1:0]       done_level;
   logic                    any_done;
`ifdef DELAY_REMAIN_EN
   logic [NUM_CH*CNT_W-1:0] remain;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int t;
   int unsigned exp_q [NUM_CH][$];

   multi_channel_delay_timer #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .cancel     (cancel),
      .retrig     (retrig),
      .delay_val  (delay_val),
      .clr_done   (clr_done),
      .busy       (busy),
      .done_pulse (done_pulse),
      .done_level (done_level),
      .any_done   (any_done)
`ifdef DELAY_REMAIN_EN
      ,
      .remain     (remain)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every observed pulse must match the head of that channel's queue.
   always @(negedge clk) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (done_pulse[ch] === 1'b1) begin
            n_cmp++;
            if (exp_q[ch].size() == 0) begin
               n_err++;
               $display("FAIL pulse_ch%0d: got unexpected pulse at cycle %0d, want none", ch, cyc);
            end else begin
               int unsigned e;
               e = exp_q[ch].pop_front();
               if (e != cyc) begin
                  n_err++;
                  $display("FAIL pulse_ch%0d: got pulse at cycle %0d, want cycle %0d", ch, cyc, e);
               end
            end
         end
      end
   end

   task automatic start_ch(input int ch, input int n, input logic rt);
      delay_val[ch*CNT_W +: CNT_W] = CNT_W'(n);
      retrig[ch] = rt;
      start[ch]  = 1'b1;
      @(negedge clk);
      start[ch]  = 1'b0;
   endtask

   task automatic clr_ch(input int ch);
      clr_done[ch] = 1'b1;
      @(negedge clk);
      clr_done[ch] = 1'b0;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      #2 reset_n = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pulse", 32'(done_pulse), 0);
      chk("rst_level", 32'(done_level), 0);
      chk("rst_any", 32'(any_done), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic 5-cycle delay on ch0
      start_ch(0, 5, 1'b0); t = cyc; exp_q[0].push_back(t + 5);
      chk("basic_busy_start", 32'(busy[0]), 1);
      wait_to(t + 4);
      chk("basic_busy_last", 32'(busy[0]), 1);
      wait_to(t + 5);
      chk("basic_busy_end", 32'(busy[0]), 0);
      chk("basic_level", 32'(done_level[0]), 1);
      chk("basic_any", 32'(any_done), 1);
      wait_to(t + 8);
      chk("basic_level_hold", 32'(done_level[0]), 1);
      clr_ch(0);
      chk("basic_clr_level", 32'(done_level[0]), 0);
      chk("basic_clr_any", 32'(any_done), 0);

      // Zero delay behaves as one
      start_ch(1, 0, 1'b0); t = cyc; exp_q[1].push_back(t + 1);
      wait_to(t + 2);
      chk("zero_level", 32'(done_level[1]), 1);
      clr_ch(1);

      // Maximum delay, no wrap
      start_ch(1, 15, 1'b0); t = cyc; exp_q[1].push_back(t + 15);
      wait_to(t + 14);
      chk("max_busy_last", 32'(busy[1]), 1);
      wait_to(t + 15);
      chk("max_busy_end", 32'(busy[1]), 0);
      chk("max_level", 32'(done_level[1]), 1);
      clr_ch(1);

      // Retrigger: second start at t+6 pushes expiry to t+16
      start_ch(2, 10, 1'b1); t = cyc;
      wait_to(t + 5);
      start_ch(2, 10, 1'b1); exp_q[2].push_back(t + 16);
      wait_to(t + 10);
      chk("retrig_busy_t10", 32'(busy[2]), 1);
      wait_to(t + 16);
      chk("retrig_level", 32'(done_level[2]), 1);
      clr_ch(2);

      // Retrig disabled: second start ignored
      start_ch(2, 10, 1'b0); t = cyc; exp_q[2].push_back(t + 10);
      wait_to(t + 5);
      start_ch(2, 10, 1'b0);
      wait_to(t + 10);
      chk("noretrig_busy", 32'(busy[2]), 0);
      chk("noretrig_level", 32'(done_level[2]), 1);
      wait_to(t + 18);
      clr_ch(2);

      // Cancel mid-count
      start_ch(3, 8, 1'b0); t = cyc;
      wait_to(t + 4);
      cancel[3] = 1'b1;
      @(negedge clk);
      cancel[3] = 1'b0;
      chk("cancel_busy", 32'(busy[3]), 0);
      wait_to(t + 12);
      chk("cancel_level", 32'(done_level[3]), 0);

      // Cancel + start from IDLE stays IDLE
      delay_val[3*CNT_W +: CNT_W] = CNT_W'(4);
      start[3] = 1'b1; cancel[3] = 1'b1;
      @(negedge clk);
      start[3] = 1'b0; cancel[3] = 1'b0;
      chk("cancel_start_busy", 32'(busy[3]), 0);
      repeat (6) @(negedge clk);
      chk("cancel_start_level", 32'(done_level[3]), 0);

      // Start on the expiry edge reloads instead of expiring
      start_ch(0, 3, 1'b1); t = cyc;
      wait_to(t + 2);
      start_ch(0, 3, 1'b1); exp_q[0].push_back(t + 6);
      chk("collide_busy", 32'(busy[0]), 1);
      wait_to(t + 6);
      chk("collide_level", 32'(done_level[0]), 1);
      wait_to(t + 8);

      // Async reset mid-operation: ch0 in DONE, ch1..3 counting
      delay_val[1*CNT_W +: CNT_W] = CNT_W'(12);
      delay_val[2*CNT_W +: CNT_W] = CNT_W'(12);
      delay_val[3*CNT_W +: CNT_W] = CNT_W'(12);
      start[3:1] = 3'b111;
      @(negedge clk);
      start[3:1] = 3'b000;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'hE);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_level", 32'(done_level), 0);
      chk("async_rst_any", 32'(any_done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (18) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 0);

      for (int ch = 0; ch < NUM_CH; ch++) begin
         chk($sformatf("pending_ch%0d", ch), 32'(exp_q[ch].size()), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multi_channel_delay_timer.md
Name: multi_channel_delay_timer

Overview:
- Parametrised successor to the single-shot power-up delay.
- Provides NUM_CH independent, software-started delay timers. Each channel has a runtime-loadable delay, a cancel input, a retrigger mode, a one-cycle done pulse and a sticky done flag.
- Used by the RFID/alarm control logic for entry-grace timing, siren hold-off and reader settle delays.

Parameters:
- NUM_CH, 4, number of independent timer channels (>=1).
- CNT_W, 16, width of each channel's delay value and down-counter (>=2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  NUM_CH  per-channel start request, sampled on the rising edge.
- cancel  input  NUM_CH  per-channel abort; no done is produced.
- retrig  input  NUM_CH  per-channel mode: 1 = start during COUNT reloads, 0 = start during COUNT is ignored.
- delay_val  input  NUM_CH*CNT_W  per-channel delay N in cycles; channel i uses bits [i*CNT_W +: CNT_W]; latched on accepted start.
- clr_done  input  NUM_CH  clears the sticky done flag.
- busy  output  NUM_CH  1 while the channel is in COUNT.
- done_pulse  output  NUM_CH  one-cycle pulse when the delay expires.
- done_level  output  NUM_CH  sticky done flag.
- any_done  output  1  OR of all done_level bits (registered-equivalent; combinational OR of registered flags).

Behaviour:
- Reset (reset_n=0, asynchronous): every channel goes to IDLE; counter=0; busy=0; done_pulse=0; done_level=0; any_done=0. Reset asserted mid-count aborts the count with no done.
- Per-channel FSM states: IDLE, COUNT, DONE. All channels are fully independent.
- Load rule: an accepted start loads counter <= (delay_val==0 ? 1 : delay_val), enters COUNT, and clears done_level.
- COUNT, each edge:
  - if counter==1: go to DONE, done_pulse<=1, done_level<=1;
  - else counter <= counter-1.
- Latency: if start is sampled at edge t with N>=1, done_pulse is high for exactly the cycle following edge t+N; busy is high from after edge t until edge t+N. N=0 behaves as N=1.
- IDLE: start -> accepted. cancel and clr_done have no effect.
- COUNT:
  - cancel -> IDLE, counter=0, no pulse.
  - start with retrig=1 -> reload from the current delay_val, staying in COUNT.
  - start with retrig=0 -> ignored.
- DONE:
  - done_level is held and busy=0.
  - clr_done -> IDLE, done_level=0.
  - start -> accepted (restart).
  - cancel -> IDLE, done_level=0.
- done_pulse is always deasserted on the edge after it is asserted, regardless of other inputs.
- Priority for simultaneous events on the same edge: cancel > start > expiry > clr_done.
  - cancel+start: cancel wins and the channel goes to IDLE.
  - start (accepted or retrig reload) on the edge where counter==1: the reload wins and no done_pulse is produced.
  - start (retrig=0) on the expiry edge: expiry proceeds normally.
  - start+clr_done in DONE: start wins.
- Arithmetic: the counter is unsigned CNT_W bits and never wraps (terminates at 1). The maximum delay is 2^CNT_W-1 cycles.

Optional Feature:
- Macro DELAY_REMAIN_EN.
- Defined: adds output port remain (NUM_CH*CNT_W), giving each channel's live counter value. It reads 0 in IDLE and DONE, and the current counter value in COUNT.
- Undefined: the port is absent and there is no extra logic. All other behaviour is identical.

Test Plan:
- Basic timing: reset_n released; ch0 delay_val=5, start pulse at edge t -> busy0=1 for 5 cycles, done_pulse0 high for exactly 1 cycle after edge t+5, done_level0=1 and any_done=1 until clr_done0.
- Zero and maximum delay: ch1 delay_val=0 -> done_pulse1 after edge t+1. With CNT_W=4, delay_val=15 -> done after edge t+15 with no wrap.
- Retrigger: ch2 retrig=1, N=10, start again at t+6 -> done at t+16 only. With retrig=0 the same stimulus -> done at t+10 and the second start is ignored.
- Cancel: ch3 N=8, cancel at t+4 -> busy3=0 from t+5, no done_pulse3, done_level3 stays 0. Simultaneous cancel+start from IDLE -> the channel stays IDLE.
- Expiry collision: ch0 N=3, retrig=1, start again on the edge where counter==1 -> no pulse, reload, done 3 cycles later.
- Async reset mid-operation: all channels counting, reset_n low between edges -> busy=0, done_level=0 immediately. After release, no spurious done_pulse occurs for 2^CNT_W cycles without a start.
